ahb_master_arbiter: RTL and testbench

//  Two-requester front end that shares one AHB master port feeding the AHB2APB bridge.
//  - Arbitrates between requesters round-robin.
//  - Sequences each accepted command as a single AHB transfer: NONSEQ address phase, then IDLE with data phase.
//  - Returns read data, error and timeout status to the winning requester.

---
 rtl/ahb_master_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_arbiter.sv
// Two-requester round-robin front end driving a single AHB master port.
// Each accepted command becomes one NONSEQ transfer followed by an IDLE data phase.
module ahb_master_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 16,
    parameter int TO_W     = 8
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    input  logic                  Hreadyout,
    input  logic [1:0]            Hresp,
    input  logic [DATA_W-1:0]     Hrdata,
    output logic                  Hwrite,
    output logic                  Hreadyin,
    output logic [1:0]            Htrans,
    output logic [ADDR_W-1:0]     Haddr,
    output logic [DATA_W-1:0]     Hwdata
);

    localparam logic [1:0]      HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]      HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0]      HRESP_ERROR   = 2'b01;
    localparam logic [TO_W-1:0] WAIT_LIM      = TO_W'(WAIT_MAX);
    localparam bit              TIMEOUT_EN    = (WAIT_MAX != 0);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t              state_q, state_d;
    logic [TO_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                last_grant_q, last_grant_d;
    logic                id_q, id_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          htrans_d;
    logic                hwrite_d;
    logic [ADDR_W-1:0]   haddr_d;
    logic [DATA_W-1:0]   hwdata_d;
    logic                rsp_valid_d, rsp_id_d, rsp_err_d, rsp_timeout_d;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic                grant_idx, accept, timeout_hit;

    // Grant: a lone requester wins outright; contention goes to the one not served last.
    always_comb begin
        grant_idx = (&req_valid) ? ~last_grant_q : req_valid[1];
        accept    = (state_q == S_IDLE) && (|req_valid);
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    assign cnt_inc     = cnt_q + TO_W'(1);
    assign timeout_hit = TIMEOUT_EN && (state_q != S_IDLE) && !Hreadyout && (cnt_inc == WAIT_LIM);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        wdata_d       = wdata_q;
        htrans_d      = Htrans;
        hwrite_d      = Hwrite;
        haddr_d       = Haddr;
        hwdata_d      = Hwdata;
        rsp_valid_d   = 1'b0;
        rsp_id_d      = rsp_id;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;

        if (timeout_hit) begin
            htrans_d      = HTRANS_IDLE;
            rsp_valid_d   = 1'b1;
            rsp_id_d      = id_q;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            cnt_d         = '0;
            state_d       = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    htrans_d = HTRANS_IDLE;
                    if (accept) begin
                        haddr_d      = grant_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                        hwrite_d     = req_write[grant_idx];
                        wdata_d      = grant_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                        id_d         = grant_idx;
                        last_grant_d = grant_idx;
                        htrans_d     = HTRANS_NONSEQ;
                        cnt_d        = '0;
                        state_d      = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (Hreadyout) begin
                        htrans_d = HTRANS_IDLE;
                        if (Hwrite) hwdata_d = wdata_q;
                        cnt_d    = '0;
                        state_d  = S_DATA;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_DATA: begin
                    if (Hreadyout) begin
                        rsp_valid_d   = 1'b1;
                        rsp_id_d      = id_q;
                        rsp_rdata_d   = Hwrite ? '0 : Hrdata;
                        rsp_err_d     = (Hresp == HRESP_ERROR);
                        rsp_timeout_d = 1'b0;
                        cnt_d         = '0;
                        state_d       = S_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            wdata_q      <= '0;
            Htrans       <= HTRANS_IDLE;
            Hwrite       <= 1'b0;
            Hreadyin     <= 1'b0;
            Haddr        <= '0;
            Hwdata       <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            wdata_q      <= wdata_d;
            Htrans       <= htrans_d;
            Hwrite       <= hwrite_d;
            Hreadyin     <= 1'b1;
            Haddr        <= haddr_d;
            Hwdata       <= hwdata_d;
            rsp_valid    <= rsp_valid_d;
            rsp_id       <= rsp_id_d;
            rsp_rdata    <= rsp_rdata_d;
            rsp_err      <= rsp_err_d;
            rsp_timeout  <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Scenario bench for ahb_master_arbiter: cycle-exact checks per task plus a response scoreboard.
module tb_ahb_master_arbiter;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic [1:0]  req_valid, req_write, req_ready;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_id, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic        Hwrite, Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr, Hwdata;

    typedef struct packed {
        logic        id;
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t sb[$];
    rsp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    ahb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_MAX(16), .TO_W(8)) dut (
        .Hclk(Hclk), .Hreset(Hreset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata),
        .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata)
    );

    always #5 Hclk = ~Hclk;

    task automatic tick;
        @(posedge Hclk);
        #1;
    endtask

    // Scoreboard: every completion pulse must match the oldest expected response.
    always @(negedge Hclk) begin
        if (!Hreset && rsp_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got rsp_valid id=%0d, required no response", rsp_id);
            end else begin
                e = sb.pop_front();
                if ({rsp_id, rsp_rdata, rsp_err, rsp_timeout} !== {e.id, e.rdata, e.err, e.to}) begin
                    n_bad++;
                    $display("FAIL sb_rsp: got id=%0d rdata=%h err=%0d to=%0d, required id=%0d rdata=%h err=%0d to=%0d",
                             rsp_id, rsp_rdata, rsp_err, rsp_timeout, e.id, e.rdata, e.err, e.to);
                end
            end
        end
    end

    task automatic test_reset;
        Hreset = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
        Hreadyout = 1'b1; Hresp = 2'b00; Hrdata = '0;
        repeat (3) tick();
        n_cmp++;
        if ({Htrans, Hwrite, Hreadyin, Haddr, Hwdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_bus: got Htrans=%b Hwrite=%b Hreadyin=%b Haddr=%h Hwdata=%h, required all 0",
                     Htrans, Hwrite, Hreadyin, Haddr, Hwdata);
        end
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
            n_bad++;
            $display("FAIL reset_rsp: got valid=%b id=%b rdata=%h err=%b to=%b, required all 0",
                     rsp_valid, rsp_id, rsp_rdata, rsp_err, rsp_timeout);
        end
        Hreset = 1'b0;
        tick();
        n_cmp++;
        if (Hreadyin !== 1'b1 || Htrans !== 2'b00) begin
            n_bad++;
            $display("FAIL post_reset: got Hreadyin=%b Htrans=%b, required 1/00", Hreadyin, Htrans);
        end
    endtask

    task automatic test_single_write;
        req_addr[31:0] = 32'h8800_0001; req_wdata[31:0] = 32'h0000_00A3;
        req_write = 2'b01; req_valid = 2'b01;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_bad++; $display("FAIL wr_ready: got %b, required 01", req_ready);
        end
        sb.push_back('{1'b0, 32'h0, 1'b0, 1'b0});
        tick(); req_valid = 2'b00;
        n_cmp++;
        if (Htrans !== 2'b10 || Haddr !== 32'h8800_0001 || Hwrite !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_addr_phase: got Htrans=%b Haddr=%h Hwrite=%b, required 10/88000001/1", Htrans, Haddr, Hwrite);
        end
        tick();
        n_cmp++;
        if (Htrans !== 2'b00 || Hwdata !== 32'h0000_00A3) begin
            n_bad++;
            $display("FAIL wr_data_phase: got Htrans=%b Hwdata=%h, required 00/000000a3", Htrans, Hwdata);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_rsp_n3: got valid=%b id=%b err=%b, required 1/0/0", rsp_valid, rsp_id, rsp_err);
        end
    endtask

    task automatic test_read_wait;
        req_addr[63:32] = 32'h8000_00A2; req_write = 2'b00; req_valid = 2'b10;
        Hreadyout = 1'b1; Hrdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_bad++; $display("FAIL rd_ready: got %b, required 10", req_ready);
        end
        sb.push_back('{1'b1, 32'h5A5A_0001, 1'b0, 1'b0});
        tick(); req_valid = 2'b00;
        n_cmp++;
        if (Htrans !== 2'b10 || Haddr !== 32'h8000_00A2 || Hwrite !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_addr_phase: got Htrans=%b Haddr=%h Hwrite=%b, required 10/800000a2/0", Htrans, Haddr, Hwrite);
        end
        tick(); Hreadyout = 1'b0;
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL rd_early_n3: got rsp_valid=%b, required 0", rsp_valid);
        end
        tick(); Hreadyout = 1'b1; Hrdata = 32'h5A5A_0001;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL rd_early_n4: got rsp_valid=%b, required 0", rsp_valid);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5A5A_0001 || rsp_id !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_rsp_n5: got valid=%b rdata=%h id=%b, required 1/5a5a0001/1", rsp_valid, rsp_rdata, rsp_id);
        end
    endtask

    task automatic test_round_robin;
        int accepts = 0;
        int cyc = 0;
        int last_cyc = 0;
        logic exp_g = 1'b0;
        logic g;
        req_addr = {32'h0000_0200, 32'h0000_0100};
        req_wdata = {32'h0000_2222, 32'h0000_1111};
        req_write = 2'b11; req_valid = 2'b11; Hreadyout = 1'b1; Hresp = 2'b00;
        #1;
        while (accepts < 4 && cyc < 60) begin
            if (req_ready != 2'b00) begin
                n_cmp++;
                if (req_ready !== (exp_g ? 2'b10 : 2'b01)) begin
                    n_bad++;
                    $display("FAIL rr_grant%0d: got req_ready=%b, required %b", accepts, req_ready, exp_g ? 2'b10 : 2'b01);
                end
                g = req_ready[1];
                sb.push_back('{g, 32'h0, 1'b0, 1'b0});
                if (accepts > 0) begin
                    n_cmp++;
                    if (cyc - last_cyc != 3) begin
                        n_bad++;
                        $display("FAIL rr_spacing%0d: got %0d cycles, required 3", accepts, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                accepts++;
                exp_g = ~exp_g;
                tick(); cyc++;
                if (accepts == 4) req_valid = 2'b00;
                n_cmp++;
                if (Haddr !== (g ? 32'h0000_0200 : 32'h0000_0100)) begin
                    n_bad++;
                    $display("FAIL rr_haddr%0d: got %h, required %h", accepts, Haddr, g ? 32'h0000_0200 : 32'h0000_0100);
                end
            end else begin
                tick(); cyc++;
            end
        end
        n_cmp++;
        if (accepts != 4) begin
            n_bad++; $display("FAIL rr_accepts: got %0d accepts, required 4", accepts);
        end
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL rr_drain: got %0d pending responses, required 0", sb.size());
        end
    endtask

    task automatic test_error;
        req_addr[31:0] = 32'h0000_0004; req_write = 2'b00; req_valid = 2'b01;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_bad++; $display("FAIL err_ready: got %b, required 01", req_ready);
        end
        sb.push_back('{1'b0, 32'hBAD0_0004, 1'b1, 1'b0});
        tick(); req_valid = 2'b00;
        tick(); Hreadyout = 1'b0; Hresp = 2'b01;
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL err_first_cycle: got rsp_valid=%b, required 0", rsp_valid);
        end
        Hreadyout = 1'b1; Hrdata = 32'hBAD0_0004;
        tick(); Hresp = 2'b00;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL err_rsp: got valid=%b err=%b to=%b, required 1/1/0", rsp_valid, rsp_err, rsp_timeout);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b1 || Htrans !== 2'b00) begin
            n_bad++;
            $display("FAIL err_after: got valid=%b err=%b Htrans=%b, required 0/1/00", rsp_valid, rsp_err, Htrans);
        end
    endtask

    task automatic test_timeout;
        int k = 1;
        req_addr[31:0] = 32'h0000_0008; req_write = 2'b00; req_valid = 2'b01;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_bad++; $display("FAIL to_ready: got %b, required 01", req_ready);
        end
        sb.push_back('{1'b0, 32'h0, 1'b1, 1'b1});
        tick(); req_valid = 2'b00; Hreadyout = 1'b0;
        while (k < 40) begin
            tick(); k++;
            if (rsp_valid === 1'b1) break;
            if (k == 16) begin
                n_cmp++;
                if (Htrans !== 2'b10) begin
                    n_bad++; $display("FAIL to_hold: got Htrans=%b at wait 15, required 10", Htrans);
                end
            end
        end
        n_cmp++;
        if (k != 17) begin
            n_bad++; $display("FAIL to_latency: got rsp at N+%0d, required N+17", k);
        end
        n_cmp++;
        if (Htrans !== 2'b00 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL to_abort: got Htrans=%b err=%b to=%b, required 00/1/1", Htrans, rsp_err, rsp_timeout);
        end
        Hreadyout = 1'b1;
        req_addr[63:32] = 32'h0000_000C; req_wdata[63:32] = 32'h0000_0077; req_write = 2'b10; req_valid = 2'b10;
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_bad++; $display("FAIL to_next_ready: got %b, required 10", req_ready);
        end
        sb.push_back('{1'b1, 32'h0, 1'b0, 1'b0});
        tick(); req_valid = 2'b00;
        repeat (4) tick();
    endtask

    task automatic test_reset_in_data;
        req_addr[31:0] = 32'h0000_0010; req_wdata[31:0] = 32'h0000_0055; req_write = 2'b01; req_valid = 2'b01;
        tick(); req_valid = 2'b00;
        tick(); Hreadyout = 1'b0;
        #2; Hreset = 1'b1;
        #1;
        n_cmp++;
        if ({Htrans, Hwrite, Hreadyin, Haddr, Hwdata, rsp_valid} !== '0) begin
            n_bad++;
            $display("FAIL rst_async: got Htrans=%b Hwrite=%b Hreadyin=%b Haddr=%h Hwdata=%h rsp_valid=%b, required all 0",
                     Htrans, Hwrite, Hreadyin, Haddr, Hwdata, rsp_valid);
        end
        repeat (2) tick();
        Hreset = 1'b0; Hreadyout = 1'b1;
        tick();
        req_addr = {32'h0000_0030, 32'h0000_0020}; req_write = 2'b11; req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_bad++; $display("FAIL rst_first_grant: got %b, required 01", req_ready);
        end
        sb.push_back('{1'b0, 32'h0, 1'b0, 1'b0});
        tick(); req_valid = 2'b00;
        n_cmp++;
        if (Haddr !== 32'h0000_0020) begin
            n_bad++; $display("FAIL rst_haddr: got %h, required 00000020", Haddr);
        end
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_round_robin();
        test_error();
        test_timeout();
        test_reset_in_data();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL final_drain: got %0d pending responses, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
